// File: rtl/reader_pie_tx.sv
// Reader-side PIE command transmitter.
// Drives the tag demodin envelope: delimiter, data-0, RTcal, TRcal, data.

module reader_pie_tx #(
  parameter int TARI  = 8,
  parameter int PW    = 4,
  parameter int DELIM = 12,
  parameter int TRCAL = 32,
  parameter int CMD_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_preamble,
  input  logic [6:0]       cmd_len,
  input  logic [CMD_W-1:0] cmd_data,
  output logic             demod_out,
  output logic             busy,
  output logic             done,
  output logic [6:0]       bits_sent
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELIM,
    S_D0,
    S_RTCAL,
    S_TRCAL,
    S_DATA,
    S_FIN
  } state_t;

  localparam logic [15:0] LEN_D0 = 16'(TARI);
  localparam logic [15:0] LEN_D1 = 16'(2 * TARI);
  localparam logic [15:0] LEN_RT = 16'(3 * TARI);
  localparam logic [15:0] LEN_TR = 16'(TRCAL);
  localparam logic [15:0] LEN_DL = 16'(DELIM);
  localparam logic [15:0] LEN_PW = 16'(PW);
  localparam logic [7:0]  CW8    = 8'(CMD_W);

  state_t           state;
  state_t           nxt_state;
  logic [15:0]      cnt;
  logic [6:0]       rem;
  logic             pre;
  logic [CMD_W-1:0] cmd_sr;

  logic [15:0]      cur_len;
  logic [15:0]      nxt_len;
  logic             nxt_bit;
  logic             sym_end;
  logic             hi_next;
  logic [6:0]       len_c;
  logic [7:0]       shamt;

  // Clamp the requested length and left-align the first bit at the MSB
  always_comb begin
    len_c = cmd_len;
    if ({1'b0, cmd_len} > CW8)
      len_c = CW8[6:0];
    shamt = CW8 - {1'b0, len_c};
  end

  // Length of the symbol currently on the line
  always_comb begin
    cur_len = LEN_D0;
    unique case (state)
      S_DELIM: cur_len = LEN_DL;
      S_D0:    cur_len = LEN_D0;
      S_RTCAL: cur_len = LEN_RT;
      S_TRCAL: cur_len = LEN_TR;
      S_DATA:  cur_len = cmd_sr[CMD_W-1] ? LEN_D1 : LEN_D0;
      default: cur_len = LEN_D0;
    endcase
  end

  // Symbol sequencing: what follows the current symbol
  always_comb begin
    nxt_state = S_FIN;
    unique case (state)
      S_DELIM: nxt_state = S_D0;
      S_D0:    nxt_state = S_RTCAL;
      S_RTCAL: nxt_state = pre ? S_TRCAL
                         : (rem != 7'd0) ? S_DATA : S_FIN;
      S_TRCAL: nxt_state = (rem != 7'd0) ? S_DATA : S_FIN;
      S_DATA:  nxt_state = (rem > 7'd1) ? S_DATA : S_FIN;
      default: nxt_state = S_FIN;
    endcase
  end

  // Bit value and length of the next data symbol
  always_comb begin
    nxt_bit = (state == S_DATA) ? cmd_sr[CMD_W-2]
                                : cmd_sr[CMD_W-1];
    nxt_len = LEN_D0;
    if (nxt_state == S_DATA)
      nxt_len = nxt_bit ? LEN_D1 : LEN_D0;
  end

  // Position within the current symbol and the level of the next cycle
  always_comb begin
    sym_end = (cnt == cur_len - 16'd1);
    hi_next = (state != S_DELIM) &&
              ((cnt + 16'd1) < (cur_len - LEN_PW));
  end

  // Main FSM; every output is a flop so the envelope cannot glitch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      rem       <= 7'd0;
      pre       <= 1'b0;
      cmd_sr    <= '0;
      demod_out <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      bits_sent <= 7'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done      <= 1'b0;
          demod_out <= 1'b1;
          if (start) begin
            pre       <= use_preamble;
            rem       <= len_c;
            cmd_sr    <= cmd_data << shamt;
            cnt       <= 16'd0;
            busy      <= 1'b1;
            bits_sent <= 7'd0;
            demod_out <= 1'b0;
            state     <= S_DELIM;
          end
        end
        S_FIN: begin
          done      <= 1'b0;
          demod_out <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          if (sym_end) begin
            if (state == S_DATA) begin
              bits_sent <= bits_sent + 7'd1;
              rem       <= rem - 7'd1;
              cmd_sr    <= cmd_sr << 1;
            end
            cnt   <= 16'd0;
            state <= nxt_state;
            if (nxt_state == S_FIN) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              demod_out <= 1'b1;
            end else begin
              demod_out <= (LEN_PW < nxt_len);
            end
          end else begin
            cnt       <= cnt + 16'd1;
            demod_out <= hi_next;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/reader_pie_tx.md
Name: reader_pie_tx

Overview:
Reader-side PIE (pulse-interval encoding) command transmitter. It drives the envelope line that feeds the tag's `demodin` input. It serialises a command word into delimiter, data-0, RTcal, optional TRcal, then data symbols, so the tag receive path can be exercised end to end at cycle accuracy. It lives in the verification/reader side of the tag design and runs on the tag's clk.

Parameters:
TARI, 8, data-0 symbol length in clk cycles; data-1 = 2*TARI, RTcal = 3*TARI
PW, 4, low pulse width ending every symbol, in cycles; legal range 1..TARI-1
DELIM, 12, delimiter low time in cycles
TRCAL, 32, TRcal symbol length in cycles; must exceed PW
CMD_W, 64, width of command data register

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request; sampled only while busy=0
use_preamble  in  1  1: send preamble (with TRcal); 0: send frame-sync (no TRcal); latched on start
cmd_len  in  7  number of bits to send; latched on start; values >CMD_W clamp to CMD_W
cmd_data  in  CMD_W  command bits; bit cmd_len-1 is sent first, bit 0 last; latched on start
demod_out  out  1  PIE envelope to tag demodin; 1 = carrier on (idle), 0 = low pulse
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the final symbol's last low cycle
bits_sent  out  7  count of data symbols fully transmitted in the current command

Behaviour:
- Reset (any time, including mid-command): demod_out=1, busy=0, done=0, bits_sent=0, FSM=IDLE. All latched command fields are cleared.
- All outputs are registered.
- FSM states: IDLE, DELIM, D0, RTCAL, TRCAL, DATA, FIN.
- Symbol rule: a symbol of length L cycles drives 1 for L-PW cycles, then 0 for PW cycles.
- DELIM drives 0 for DELIM cycles.
- IDLE + start: latch fields, set busy=1, go to DELIM.
  - demod_out=0 in the first cycle after the sampling edge (waveform cycle 0).
- Sequence: DELIM -> D0 (L=TARI) -> RTCAL (L=3*TARI).
  - Then TRCAL (L=TRCAL) if use_preamble=1, else go straight on.
  - Then DATA if the latched length is >0, else FIN.
- DATA: one symbol per bit, MSB-first from bit len-1 down to 0.
  - A 0 bit uses L=TARI; a 1 bit uses L=2*TARI.
  - bits_sent increments in the cycle after each symbol's last low cycle.
- FIN lasts one cycle: demod_out=1, done=1, busy=0, then return to IDLE.
  - bits_sent holds its final value until the next start, which clears it.
- Timing: if the waveform occupies cycles 0..T-1, done is high in cycle T only.
  - T = DELIM + TARI + 3*TARI + (use_preamble ? TRCAL : 0) + Σ symbol lengths.
- start while busy=1 is ignored. No queuing; cmd_data changes while busy have no effect.
- start coincident with FIN is ignored. A new command needs start in a cycle where busy=0.
- cmd_len=0 sends only the preamble/frame-sync, then FIN.
- cmd_len>CMD_W sends exactly CMD_W bits and bits_sent ends at CMD_W.
- Counters: one 16-bit symbol-cycle counter and a 7-bit bit index. No wrap is possible within legal parameters.
- demod_out never glitches. It is the direct output of one flop.

Test Plan:
1. Defaults; start with use_preamble=1, cmd_len=4, cmd_data[3:0]=1010 -> demod_out:
   - 0 in cycles 0-11, 1 in 12-15, 0 in 16-19
   - 1 in 20-39, 0 in 40-43
   - 1 in 44-71, 0 in 72-75
   - 1 in 76-87, 0 in 88-91
   - 1 in 92-95, 0 in 96-99
   - 1 in 100-111, 0 in 112-115
   - 1 in 116-119, 0 in 120-123
   - done=1 only in cycle 124; bits_sent=4; busy low at 124.
2. Same, use_preamble=0 -> no TRcal segment; first data symbol's high starts at cycle 44; done at cycle 92.
3. cmd_len=0, use_preamble=0 -> 44-cycle frame-sync; done at cycle 44; bits_sent=0.
4. Assert start again at cycle 50 of test 1 with different cmd_data -> waveform identical to test 1; no second done.
5. Assert reset at cycle 60 of test 1 -> demod_out=1, busy=0 immediately (asynchronous). After release, a new start produces a full test-1 waveform from cycle 0.
6. cmd_len=100, cmd_data=all ones -> 64 data-1 symbols (16 cycles each); bits_sent=64; done at cycle 76+1024=1100.
